mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 LINE_WORDS, 4, 32-bit words per line transfer; legal values are powers of 2 from 2 to 16.
REQ-002 ADDR_W, 32, byte-address width.
REQ-003 clk  in  1  system clock, single domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ic_req  in  1  icache line-fill request, held high until done pulses for icache.
REQ-006 ic_addr  in  ADDR_W  icache line address, stable while ic_req is high.
REQ-007 dc_req  in  1  dcache request (fill or writeback), held high until done pulses for dcache.
REQ-008 dc_we  in  1  1 = dcache writeback, 0 = dcache fill; stable while dc_req is high.
REQ-009 dc_addr  in  ADDR_W  dcache line address, stable while dc_req is high.
REQ-010 dc_wdata  in  32  current writeback word, indexed by the beat count.
REQ-011 dc_wdata_ack  out  1  current writeback word has been consumed; dcache advances to the next word.
REQ-012 resp_valid  out  1  resp_data carries a fill word.
REQ-013 resp_data  out  32  fill word, delivered in ascending order.
REQ-014 resp_dc  out  1  owner of the current transfer: 1 = dcache, 0 = icache.
REQ-015 done  out  1  one-cycle pulse marking transfer complete for the owner given by resp_dc.
REQ-016 mem_cmd_valid/mem_cmd_ready  out/in  1/1  command handshake to the memory side.
REQ-017 mem_cmd_rnw  out  1  1 = read line, 0 = write line.
REQ-018 mem_cmd_addr  out  ADDR_W  line address, with the low log2(LINE_WORDS)+2 bits forced to 0.
REQ-019 mem_wdata/mem_wdata_valid/mem_wdata_ready  out/out/in  32/1/1  write-beat handshake.
REQ-020 mem_rdata/mem_rdata_valid  in/in  32/1  read beats; the memory side never backpressures this path.

Function
REQ-021 States: IDLE, CMD, WBEAT, RBEAT, DONE.
REQ-022 IDLE: when any request is high, latch the winner's owner, rnw and address, then go to CMD on the next cycle; with no request, stay in IDLE.
REQ-023 CMD: assert mem_cmd_valid; on mem_cmd_ready, go to WBEAT if the transfer is a write, otherwise RBEAT; the command fields stay stable while waiting.
REQ-024 WBEAT: mem_wdata = dc_wdata and mem_wdata_valid = 1; each accepted beat pulses dc_wdata_ack and increments the beat counter; the last beat goes to DONE.
REQ-025 RBEAT: each mem_rdata_valid produces, in the same cycle, resp_valid = 1 and resp_data = mem_rdata, and increments the beat counter; the last beat goes to DONE.
REQ-026 DONE: done = 1 for exactly one cycle, then return to IDLE; a new grant can be issued no earlier than the cycle after DONE.
REQ-027 The beat counter is log2(LINE_WORDS) bits, clears on entry to CMD, and its wrap to 0 marks the last beat.
REQ-028 resp_dc stays constant from the grant cycle through DONE.
REQ-029 The minimum read latency from grant is 1 + LINE_WORDS + 1 cycles with zero memory wait.
REQ-030 Request inputs are sampled only in IDLE; a request that drops mid-transfer does not abort the transfer.
REQ-031 A beat handshake outside the state expecting it is ignored and does not move the counter.

Reset
REQ-032 While rst is high: state goes to IDLE, the counter to 0 and the priority pointer to icache; all valid, ack and done outputs are 0; the data, address and resp_dc outputs are 0.
REQ-033 A reset asserted mid-transfer abandons the transfer with no done pulse; requesters re-request after reset.

Configuration
REQ-034 ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the requester not granted last wins; the pointer updates in DONE.
REQ-035 ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache over icache; the pointer logic is absent.

Structure
REQ-036 The state encodings, the owner encoding (OWN_IC = 0, OWN_DC = 1) and the LINE_WORDS legality check live in the shared memory-system defines package.
REQ-037 The grant selection is one sub-module, arb_pick; the FSM, counter and datapath muxing stay in mem_arbiter.

Verification
REQ-038 ic_req alone, addr 0x1000_0014, zero-wait memory -> cmd addr 0x1000_0010, rnw = 1; 4 resp_valid with resp_dc = 0; done on cycle 6.
REQ-039 dc_req with dc_we = 1, dc_wdata words 0xA0..0xA3, mem_wdata_ready low on the 2nd beat for 3 cycles -> 4 beats in order, 4 dc_wdata_ack pulses, one done with resp_dc = 1.
REQ-040 ic_req and dc_req rise together and are held for two transfers -> with the macro: dc first, then ic; without it: dc is granted twice before ic.
REQ-041 mem_cmd_ready held low for 10 cycles -> mem_cmd_valid and the command fields stay stable; no beats and no done.
REQ-042 rst asserted during the 2nd read beat -> next cycle: state IDLE, all outputs 0, no done; a fresh ic_req afterwards completes normally.
REQ-043 Spurious mem_rdata_valid in IDLE or CMD -> no resp_valid and the counter is unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared memory-system definitions: arbiter FSM state encoding, owner
//   encoding and the line-size legality check.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WBEAT = 3'd2,
    ST_RBEAT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // A line is 2..16 words and must be a power of two so the beat counter wraps.
  function automatic bit line_words_legal(input int unsigned n);
    return (n >= 32'd2) && (n <= 32'd16) && ((n & (n - 32'd1)) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
//------------------------------------------------------------------------------
// arb_pick
//   Grant selection between the icache and dcache requesters.
//   ARB_ROUND_ROBIN_EN defined  : on a tie the requester not granted last wins.
//   ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache over icache.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_owner_i,
`endif
  output logic any_req_o,
  output logic owner_o
);

  // Decide the winner among the currently raised requests.
  always_comb begin
    any_req_o = ic_req_i | dc_req_i;
`ifdef ARB_ROUND_ROBIN_EN
    if (ic_req_i && dc_req_i) begin
      owner_o = ~last_owner_i;
    end else begin
      owner_o = dc_req_i ? OWN_DC : OWN_IC;
    end
`else
    owner_o = dc_req_i ? OWN_DC : OWN_IC;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//   Two-requester (icache / dcache) line-transfer arbiter in front of a
//   single memory port. Command handshake, then LINE_WORDS write or read
//   beats, then a one-cycle done pulse to the owner.
//   Optional macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [31:0]       dc_wdata_i,
  output logic              dc_wdata_ack_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_dc_o,
  output logic              done_o,
  output logic              mem_cmd_valid_o,
  input  logic              mem_cmd_ready_i,
  output logic              mem_cmd_rnw_o,
  output logic [ADDR_W-1:0] mem_cmd_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_wdata_valid_o,
  input  logic              mem_wdata_ready_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rdata_valid_i
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] C_LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  generate
    if (!line_words_legal(LINE_WORDS)) begin : g_bad_line_words
      $error("mem_arbiter: LINE_WORDS must be a power of 2 from 2 to 16");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              owner_q, owner_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pick_any;
  logic              pick_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q;

  // Remember who was served last; updated only when a transfer completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_IC;
    end else if (state_q == ST_DONE) begin
      last_q <= owner_q;
    end
  end
`endif

  arb_pick u_arb_pick (
    .ic_req_i     (ic_req_i),
    .dc_req_i     (dc_req_i),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner_i (last_q),
`endif
    .any_req_o    (pick_any),
    .owner_o      (pick_owner)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State, beat counter and latched transfer descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IC;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic and output muxing; outputs are forced quiet during reset.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    owner_d           = owner_q;
    rnw_d             = rnw_q;
    addr_d            = addr_q;
    dc_wdata_ack_o    = 1'b0;
    resp_valid_o      = 1'b0;
    resp_data_o       = '0;
    resp_dc_o         = owner_q;
    done_o            = 1'b0;
    mem_cmd_valid_o   = 1'b0;
    mem_cmd_rnw_o     = rnw_q;
    mem_cmd_addr_o    = addr_q;
    mem_wdata_o       = '0;
    mem_wdata_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d   = pick_owner;
          rnw_d     = (pick_owner == OWN_DC) ? ~dc_we_i : 1'b1;
          addr_d    = ((pick_owner == OWN_DC) ? dc_addr_i : ic_addr_i) & C_LINE_MASK;
          cnt_d     = '0;
          resp_dc_o = pick_owner;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        mem_cmd_valid_o = 1'b1;
        if (mem_cmd_ready_i) begin
          state_d = rnw_q ? ST_RBEAT : ST_WBEAT;
        end
      end
      ST_WBEAT: begin
        mem_wdata_o       = dc_wdata_i;
        mem_wdata_valid_o = 1'b1;
        if (mem_wdata_ready_i) begin
          dc_wdata_ack_o = 1'b1;
          cnt_d          = cnt_inc;
          if (cnt_inc == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RBEAT: begin
        if (mem_rdata_valid_i) begin
          resp_valid_o = 1'b1;
          resp_data_o  = mem_rdata_i;
          cnt_d        = cnt_inc;
          if (cnt_inc == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) begin
      dc_wdata_ack_o    = 1'b0;
      resp_valid_o      = 1'b0;
      resp_data_o       = '0;
      resp_dc_o         = 1'b0;
      done_o            = 1'b0;
      mem_cmd_valid_o   = 1'b0;
      mem_cmd_rnw_o     = 1'b0;
      mem_cmd_addr_o    = '0;
      mem_wdata_o       = '0;
      mem_wdata_valid_o = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter (LINE_WORDS = 4).
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_wdata_i;
  logic        dc_wdata_ack_o;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_dc_o;
  logic        done_o;
  logic        mem_cmd_valid_o;
  logic        mem_cmd_ready_i;
  logic        mem_cmd_rnw_o;
  logic [31:0] mem_cmd_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wdata_valid_o;
  logic        mem_wdata_ready_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rdata_valid_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .ic_req_i          (ic_req_i),
    .ic_addr_i         (ic_addr_i),
    .dc_req_i          (dc_req_i),
    .dc_we_i           (dc_we_i),
    .dc_addr_i         (dc_addr_i),
    .dc_wdata_i        (dc_wdata_i),
    .dc_wdata_ack_o    (dc_wdata_ack_o),
    .resp_valid_o      (resp_valid_o),
    .resp_data_o       (resp_data_o),
    .resp_dc_o         (resp_dc_o),
    .done_o            (done_o),
    .mem_cmd_valid_o   (mem_cmd_valid_o),
    .mem_cmd_ready_i   (mem_cmd_ready_i),
    .mem_cmd_rnw_o     (mem_cmd_rnw_o),
    .mem_cmd_addr_o    (mem_cmd_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_wdata_valid_o (mem_wdata_valid_o),
    .mem_wdata_ready_i (mem_wdata_ready_i),
    .mem_rdata_i       (mem_rdata_i),
    .mem_rdata_valid_i (mem_rdata_valid_i)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ic_req_i          = 1'b0;
    ic_addr_i         = '0;
    dc_req_i          = 1'b0;
    dc_we_i           = 1'b0;
    dc_addr_i         = '0;
    dc_wdata_i        = '0;
    mem_cmd_ready_i   = 1'b0;
    mem_wdata_ready_i = 1'b0;
    mem_rdata_i       = '0;
    mem_rdata_valid_i = 1'b0;
  endtask

  // All valid/ack/done/owner outputs low and data/address outputs zero.
  task automatic check_quiet(input string tag);
    check_val({tag, "_ctl"}, 32'({mem_cmd_valid_o, mem_wdata_valid_o, dc_wdata_ack_o,
                                  resp_valid_o, done_o, resp_dc_o, mem_cmd_rnw_o}), 32'd0);
    check_val({tag, "_addr"}, mem_cmd_addr_o, 32'd0);
    check_val({tag, "_rdata"}, resp_data_o, 32'd0);
    check_val({tag, "_wdata"}, mem_wdata_o, 32'd0);
  endtask

  // icache-only read with zero-wait memory; grant on cycle 0, done on cycle 6.
  task automatic read_zero_wait(input string tag, input logic [31:0] addr,
                                input logic [31:0] exp_addr, input logic [31:0] base);
    mem_cmd_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ic_req_i          = (c <= 6);
      ic_addr_i         = addr;
      mem_rdata_valid_i = (c >= 2 && c <= 5);
      mem_rdata_i       = base + 32'(c);
      @(negedge clk);
      check_val({tag, "_cmd_valid"}, 32'(mem_cmd_valid_o), 32'(c == 1));
      if (c == 1) begin
        check_val({tag, "_cmd_addr"}, mem_cmd_addr_o, exp_addr);
        check_val({tag, "_cmd_rnw"}, 32'(mem_cmd_rnw_o), 32'd1);
      end
      check_val({tag, "_resp_valid"}, 32'(resp_valid_o), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        check_val({tag, "_resp_data"}, resp_data_o, base + 32'(c));
      end
      check_val({tag, "_done"}, 32'(done_o), 32'(c == 6));
      check_val({tag, "_resp_dc"}, 32'(resp_dc_o), 32'd0);
      tick;
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] wd_tab [0:10];
    int          seq [0:3];
    int          nd;
    int          ic_cnt;
    int          dc_cnt;
    int          n_ack;

    // ---------------- reset, with requests and handshakes asserted -------------
    idle_inputs();
    rst               = 1'b1;
    ic_req_i          = 1'b1;
    dc_req_i          = 1'b1;
    dc_addr_i         = 32'hFFFF_FFFF;
    dc_wdata_i        = 32'h1234_5678;
    mem_cmd_ready_i   = 1'b1;
    mem_rdata_valid_i = 1'b1;
    mem_rdata_i       = 32'hCAFE_0000;
    tick; tick;
    @(negedge clk);
    check_quiet("rst");
    tick;
    idle_inputs();
    rst = 1'b0;
    tick;

    // ---------------- icache read, zero-wait memory ---------------------------
    read_zero_wait("rd1", 32'h1000_0014, 32'h1000_0010, 32'h0000_0100);

    // ---------------- dcache writeback with stalled 2nd beat ------------------
    wd_tab = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA1,
               32'hA2, 32'hA3, 32'h0, 32'h0};
    n_ack           = 0;
    mem_cmd_ready_i = 1'b1;
    dc_we_i         = 1'b1;
    dc_addr_i       = 32'h2000_0048;
    dc_wdata_i      = 32'hA0;
    for (int c = 0; c < 11; c++) begin
      dc_req_i          = (c <= 9);
      mem_wdata_ready_i = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 1) begin
        check_val("wr_cmd_addr", mem_cmd_addr_o, 32'h2000_0040);
        check_val("wr_cmd_rnw", 32'(mem_cmd_rnw_o), 32'd0);
      end
      check_val("wr_wvalid", 32'(mem_wdata_valid_o), 32'(c >= 2 && c <= 8));
      if (c >= 2 && c <= 8) begin
        check_val("wr_wdata", mem_wdata_o, wd_tab[c]);
      end
      check_val("wr_ack", 32'(dc_wdata_ack_o), 32'(c == 2 || (c >= 6 && c <= 8)));
      check_val("wr_resp_valid", 32'(resp_valid_o), 32'd0);
      check_val("wr_done", 32'(done_o), 32'(c == 9));
      if (c <= 9) begin
        check_val("wr_resp_dc", 32'(resp_dc_o), 32'd1);
      end
      if (dc_wdata_ack_o) begin
        n_ack++;
        dc_wdata_i = dc_wdata_i + 32'd1;
      end
      tick;
    end
    check_val("wr_ack_count", 32'(n_ack), 32'd4);
    idle_inputs();

    // ---------------- simultaneous requests, two transfers each ---------------
    rst = 1'b1;
    tick;
    rst               = 1'b0;
    ic_req_i          = 1'b1;
    ic_addr_i         = 32'h0000_1000;
    dc_req_i          = 1'b1;
    dc_we_i           = 1'b0;
    dc_addr_i         = 32'h0000_2000;
    mem_cmd_ready_i   = 1'b1;
    mem_rdata_valid_i = 1'b1;
    nd     = 0;
    ic_cnt = 0;
    dc_cnt = 0;
    seq    = '{-1, -1, -1, -1};
    for (int cyc = 0; cyc < 200 && nd < 4; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        seq[nd] = int'(resp_dc_o);
        nd++;
        if (resp_dc_o) begin
          dc_cnt++;
          if (dc_cnt == 2) dc_req_i = 1'b0;
        end else begin
          ic_cnt++;
          if (ic_cnt == 2) ic_req_i = 1'b0;
        end
      end
      tick;
    end
    check_val("arb_ndone", 32'(nd), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    check_val("arb_seq0", 32'(seq[0]), 32'd1);
    check_val("arb_seq1", 32'(seq[1]), 32'd0);
    check_val("arb_seq2", 32'(seq[2]), 32'd1);
    check_val("arb_seq3", 32'(seq[3]), 32'd0);
`else
    check_val("arb_seq0", 32'(seq[0]), 32'd1);
    check_val("arb_seq1", 32'(seq[1]), 32'd1);
    check_val("arb_seq2", 32'(seq[2]), 32'd0);
    check_val("arb_seq3", 32'(seq[3]), 32'd0);
`endif
    idle_inputs();
    tick;

    // ---------------- spurious beat in IDLE, stalled command, spurious in CMD -
    mem_rdata_valid_i = 1'b1;
    mem_rdata_i       = 32'hDEAD_0001;
    @(negedge clk);
    check_val("spur_idle_rvalid", 32'(resp_valid_o), 32'd0);
    tick;
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h3000_007C;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check_val("stall_cmd_valid", 32'(mem_cmd_valid_o), 32'd1);
        check_val("stall_cmd_addr", mem_cmd_addr_o, 32'h3000_0070);
        check_val("stall_cmd_rnw", 32'(mem_cmd_rnw_o), 32'd1);
      end
      check_val("stall_rvalid", 32'(resp_valid_o), 32'd0);
      check_val("stall_done", 32'(done_o), 32'd0);
      tick;
    end
    mem_cmd_ready_i = 1'b1;
    @(negedge clk);
    check_val("acc_cmd_valid", 32'(mem_cmd_valid_o), 32'd1);
    check_val("spur_cmd_rvalid", 32'(resp_valid_o), 32'd0);
    tick;
    mem_cmd_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_i = 32'h300 + 32'(k);
      @(negedge clk);
      check_val("post_rvalid", 32'(resp_valid_o), 32'd1);
      check_val("post_rdata", resp_data_o, 32'h300 + 32'(k));
      check_val("post_done_early", 32'(done_o), 32'd0);
      tick;
    end
    mem_rdata_valid_i = 1'b0;
    @(negedge clk);
    check_val("post_done", 32'(done_o), 32'd1);
    tick;
    idle_inputs();
    tick;

    // ---------------- reset during the 2nd read beat --------------------------
    mem_cmd_ready_i = 1'b1;
    ic_addr_i       = 32'h4000_0000;
    for (int c = 0; c < 8; c++) begin
      ic_req_i          = (c <= 3);
      rst               = (c == 3);
      mem_rdata_valid_i = (c >= 2);
      mem_rdata_i       = 32'h500 + 32'(c);
      @(negedge clk);
      if (c == 2) begin
        check_val("mrst_beat0", 32'(resp_valid_o), 32'd1);
      end
      if (c >= 3) begin
        check_quiet("mrst");
      end
      tick;
    end
    idle_inputs();
    read_zero_wait("rd2", 32'h4000_0024, 32'h4000_0020, 32'h0000_0700);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
